// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // One buffered writeback: destination register and its data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Which FIFO head owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_MEM
  } grant_e;

  // One-hot of a destination register, or zero when the entry is not valid.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic                  valid,
                                                    input logic [REG_ADDR_W-1:0] rd);
    rd_onehot = valid ? (NUM_REGS'(1) << rd) : '0;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of writeback requests. Slot 0 is always the head;
// a pop shifts slot 1 forward. Also exports the one-hot destination mask of
// the entries it will hold after the coming edge.
module wb_fifo2
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  wb_req_t             i_push_req,
  input  logic                i_pop,
  output logic [1:0]          o_count,
  output wb_req_t             o_head,
  output logic [NUM_REGS-1:0] o_nxt_mask
);

  logic [1:0] r_count;
  wb_req_t    r_slot0;
  wb_req_t    r_slot1;

  logic [1:0] w_count_nxt;
  wb_req_t    w_slot0_nxt;
  wb_req_t    w_slot1_nxt;

  // Next state: apply the pop first, then place a push in the first free slot.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_count_nxt = r_count;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (i_pop) begin
      w_slot0_nxt = r_slot1;
      w_count_nxt = r_count - 2'd1;
    end
    if (i_push) begin
      if (w_count_nxt == 2'd0) begin
        w_slot0_nxt = i_push_req;
      end else begin
        w_slot1_nxt = i_push_req;
      end
      w_count_nxt = w_count_nxt + 2'd1;
    end
  end

  // Occupancy register; the only state that reset has to clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values; blocking '=' stays in always_comb.
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: the slots are deliberately not reset; r_count alone decides which of them hold live data.
    r_slot0 <= w_slot0_nxt;
    r_slot1 <= w_slot1_nxt;
  end

  assign o_count    = r_count;
  assign o_head     = r_slot0;
  assign o_nxt_mask = rd_onehot(w_count_nxt != 2'd0, w_slot0_nxt.rd)
                    | rd_onehot(w_count_nxt == 2'd2, w_slot1_nxt.rd);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: buffers ALU and MEM results in two 2-entry FIFOs and
// drives the single register-file write port, MEM first with an ALU
// anti-starvation override. Optional macro REGWB_BYPASS_EN adds a
// write-to-read bypass on the BusA/BusB read tap.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic                  RegWr,
  output logic [REG_ADDR_W-1:0] RW,
  output logic [DATA_W-1:0]     BusW,
  output logic [NUM_REGS-1:0]   pend_mask,
  input  logic [REG_ADDR_W-1:0] RA,
  input  logic [REG_ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0]     BusA_in,
  input  logic [DATA_W-1:0]     BusB_in,
  output logic [DATA_W-1:0]     BusA_out,
  output logic [DATA_W-1:0]     BusB_out
);

  localparam int STARVE_W = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [1:0]          w_alu_count;
  logic [1:0]          w_mem_count;
  wb_req_t             w_alu_head;
  wb_req_t             w_mem_head;
  logic [NUM_REGS-1:0] w_alu_nxt_mask;
  logic [NUM_REGS-1:0] w_mem_nxt_mask;
  logic                w_alu_push;
  logic                w_mem_push;
  logic                w_alu_hv;
  logic                w_mem_hv;
  grant_e              w_grant;
  logic [STARVE_W-1:0] r_starve;
  logic [NUM_REGS-1:0] r_pend_mask;

  // Ready depends only on registered occupancy; held low during reset.
  assign alu_ready  = rst_n && (w_alu_count < 2'd2);
  assign mem_ready  = rst_n && (w_mem_count < 2'd2);
  // Writes to r0 are acknowledged but never buffered.
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign w_alu_hv   = (w_alu_count != 2'd0);
  assign w_mem_hv   = (w_mem_count != 2'd0);

  wb_fifo2 u_alu_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_alu_push),
    .i_push_req ('{rd: alu_rd, data: alu_data}),
    .i_pop      (w_grant == GNT_ALU),
    .o_count    (w_alu_count),
    .o_head     (w_alu_head),
    .o_nxt_mask (w_alu_nxt_mask)
  );

  wb_fifo2 u_mem_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_mem_push),
    .i_push_req ('{rd: mem_rd, data: mem_data}),
    .i_pop      (w_grant == GNT_MEM),
    .o_count    (w_mem_count),
    .o_head     (w_mem_head),
    .o_nxt_mask (w_mem_nxt_mask)
  );

  // MEM wins contention unless ALU has already waited STARVE_MAX grants.
  always_comb begin
    w_grant = GNT_NONE;
    if (w_alu_hv && w_mem_hv) begin
      w_grant = (r_starve == STARVE_LIM) ? GNT_ALU : GNT_MEM;
    end else if (w_alu_hv) begin
      w_grant = GNT_ALU;
    end else if (w_mem_hv) begin
      w_grant = GNT_MEM;
    end
  end

  // Register-file write port driven from the granted head; silent in reset.
  always_comb begin
    RegWr = 1'b0;
    RW    = '0;
    BusW  = '0;
    if (rst_n) begin
      case (w_grant)
        GNT_ALU: begin
          RegWr = 1'b1;
          RW    = w_alu_head.rd;
          BusW  = w_alu_head.data;
        end
        GNT_MEM: begin
          RegWr = 1'b1;
          RW    = w_mem_head.rd;
          BusW  = w_mem_head.data;
        end
        default: ;
      endcase
    end
  end

  // Count consecutive MEM wins while ALU waits; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_grant == GNT_ALU || !w_alu_hv) begin
      r_starve <= '0;
    end else if (w_grant == GNT_MEM && r_starve != STARVE_LIM) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  // Registered pending mask of every entry held after this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_mask <= '0;
    end else begin
      r_pend_mask <= w_alu_nxt_mask | w_mem_nxt_mask;
    end
  end

  assign pend_mask = r_pend_mask;

`ifdef REGWB_BYPASS_EN
  // Forward the in-flight write onto a matching read port (never r0).
  assign BusA_out = (RegWr && RW == RA && RA != '0) ? BusW : BusA_in;
  assign BusB_out = (RegWr && RW == RB && RB != '0) ? BusW : BusB_in;
`else
  // Read tap passes straight through; read addresses are not needed.
  assign BusA_out = BusA_in;
  assign BusB_out = BusB_in;
  logic w_unused_rd;
  assign w_unused_rd = ^{RA, RB};
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have the parameter STARVE_MAX, default 3: the maximum number of consecutive MEM grants while ALU waits.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the ports alu_valid / mem_valid, input, 1 bit: a writeback request is offered.
REQ-005 The block SHALL have the ports alu_rd / mem_rd, input, 5 bits: the destination register.
REQ-006 The block SHALL have the ports alu_data / mem_data, input, 32 bits: the write data.
REQ-007 The block SHALL have the ports alu_ready / mem_ready, output, 1 bit: the request is accepted on this edge if valid.
REQ-008 The block SHALL have the ports RegWr, RW[4:0] and BusW[31:0], outputs: they drive the register file write port.
REQ-009 The block SHALL have the port pend_mask, output, 32 bits: bit r is 1 while any buffered entry targets register r.
REQ-010 The block SHALL have the ports RA/RB[4:0] and BusA_in/BusB_in[31:0], inputs, and BusA_out/BusB_out[31:0], outputs: the read-path tap.

Function
REQ-011 The block SHALL hold one 2-entry in-order FIFO per requester; ready = (count < 2), computed from registered count only, with no pass-through when full.
REQ-012 The block SHALL enqueue a request on valid && ready at the clock edge; requests with rd == 0 SHALL be accepted and discarded, never enqueued.
REQ-013 The block SHALL drive the write port combinationally from the FIFO heads: RegWr = 1 if either head is valid; RW/BusW come from the granted head; otherwise RW = 0 and BusW = 0.
REQ-014 The block SHALL arbitrate as follows: only one head valid -> it wins; both valid -> MEM wins unless starve_cnt == STARVE_MAX, in which case ALU wins.
REQ-015 The block SHALL treat starve_cnt as a 2-bit-minimum counter: +1 on a MEM grant while the ALU head is valid; cleared on an ALU grant or when the ALU FIFO is empty; saturating at STARVE_MAX.
REQ-016 The granted head SHALL dequeue at the same edge the register file writes; exactly one write per cycle.
REQ-017 Latency SHALL be: a request accepted at edge k into an empty FIFO with no contention appears on the write port during cycle k..k+1 and is written at edge k+1.
REQ-018 Simultaneous enqueue and dequeue on the same FIFO SHALL leave count unchanged and preserve order.
REQ-019 Ordering between ALU and MEM writes to the same rd is not guaranteed; the issuing logic SHALL stall on pend_mask.
REQ-020 pend_mask SHALL be the registered OR of the one-hot rd of all valid FIFO entries, updated at every edge.

Reset
REQ-021 With rst_n low at an edge, both FIFOs SHALL empty, starve_cnt = 0 and pend_mask = 0; RegWr, RW and BusW then read 0.
REQ-022 alu_ready/mem_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-023 Reset mid-operation SHALL drop buffered entries with no register file write.

Configuration
REQ-024 The macro REGWB_BYPASS_EN SHALL control the read-path bypass. When defined, BusA_out = BusW if RegWr && RW == RA && RA != 0, else BusA_in; BusB_out follows the same rule with RB.
REQ-025 When REGWB_BYPASS_EN is undefined, BusA_out = BusA_in and BusB_out = BusB_in, with no comparator logic.

Structure
REQ-026 The package regfile_pkg SHALL hold REG_ADDR_W = 5, DATA_W = 32 and the packed typedef wb_req_t {rd, data}.
REQ-027 The block SHALL instantiate the sub-module wb_fifo2 (a 2-entry FIFO of wb_req_t with count, head and push/pop) twice.

Verification
REQ-028 Bench scenario: ALU-only: alu rd=5, data=0xDEADBEEF accepted at edge 1 -> RegWr=1, RW=5, BusW=0xDEADBEEF in cycle 1..2; pend_mask[5] = 1 for that cycle only.
REQ-029 Bench scenario: contention: both valid every cycle with STARVE_MAX=3 -> grant sequence MEM, MEM, MEM, ALU, repeating.
REQ-030 Bench scenario: back-pressure: hold MEM valid for 4 cycles while ALU saturates -> mem_ready drops to 0 after 2 accepts, no entry is lost, and FIFO order is preserved.
REQ-031 Bench scenario: rd=0: alu rd=0, data=0x1 -> alu_ready=1, RegWr stays 0, pend_mask stays 0.
REQ-032 Bench scenario: reset mid-operation: fill both FIFOs, pulse rst_n low for one edge -> RegWr=0, pend_mask=0, readies=0, then readies=1 on the next cycle.
REQ-033 Bench scenario: bypass with REGWB_BYPASS_EN: RegWr with RW=7, BusW=0x55 and RA=7 -> BusA_out=0x55; without the macro -> BusA_out=BusA_in.
